// File: rtl/mca_lut_sched.sv
// Scheduler and sample history for the lookahead/lookback LUT4 multi-cycle accumulators.
// Freezes a history snapshot every DOWNSAMPLE samples, launches both banks, then emits their saturated sum.
module mca_lut_sched #(
    parameter int W             = 32,
    parameter int NUM_ADDITIONS = 16,
    parameter int DOWNSAMPLE    = 24,
    parameter int MCA_LATENCY   = 17
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [3:0]                 s_in,
    input  logic                       s_valid,
    output logic                       mca_enable,
    output logic                       mca_start,
    output logic [4*NUM_ADDITIONS-1:0] s_la,
    output logic [4*NUM_ADDITIONS-1:0] s_lb,
    input  logic signed [W-1:0]        res_la,
    input  logic signed [W-1:0]        res_lb,
    output logic signed [W-1:0]        est_out,
    output logic                       est_valid,
    output logic                       busy,
    output logic                       overrun
);
    localparam int HIST = 2 * NUM_ADDITIONS;
    localparam int FW   = $clog2(HIST + 1);
    localparam int SW   = $clog2(DOWNSAMPLE);
    localparam int CW   = $clog2(MCA_LATENCY);

    typedef enum logic [1:0] {IDLE, START, WAIT, COMBINE} state_t;

    // The oldest slot is only ever seen after a shift pushes it out, so only the
    // newest HIST-1 samples are stored; the incoming sample completes the window.
    logic [4*(HIST-1)-1:0] hist_r;
    logic [4*HIST-1:0]     hist_shift_s;
    logic [FW-1:0]         fill_r;
    logic [SW-1:0]         samp_r;
    logic [CW-1:0]         wait_r;
    state_t                state_r;
    logic                  full_s;
    logic                  trigger_s;

    assign hist_shift_s = {hist_r, s_in};
    assign full_s       = (fill_r == FW'(HIST));
    assign trigger_s    = s_valid && full_s && (samp_r == SW'(DOWNSAMPLE - 1));
    assign busy         = (state_r != IDLE);

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            sat_add = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_add = sum[W-1:0];
        end
    endfunction

    // History shift plus fill and decimation counters, running in every state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_r <= '0;
            fill_r <= '0;
            samp_r <= '0;
        end else if (s_valid) begin
            hist_r <= hist_shift_s[4*(HIST-1)-1:0];
            if (!full_s) begin
                fill_r <= fill_r + FW'(1);
            end else if (samp_r == SW'(DOWNSAMPLE - 1)) begin
                samp_r <= '0;
            end else begin
                samp_r <= samp_r + SW'(1);
            end
        end
    end

    // Launch / wait / combine sequencer with registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            wait_r     <= '0;
            mca_enable <= 1'b0;
            mca_start  <= 1'b0;
            s_la       <= '0;
            s_lb       <= '0;
            est_out    <= '0;
            est_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mca_enable <= 1'b1;
            mca_start  <= 1'b0;
            est_valid  <= 1'b0;
            overrun    <= trigger_s && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (trigger_s) begin
                        state_r   <= START;
                        mca_start <= 1'b1;
                        s_la      <= hist_shift_s[4*NUM_ADDITIONS-1:0];
                        s_lb      <= hist_shift_s[4*HIST-1:4*NUM_ADDITIONS];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    wait_r  <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (wait_r == CW'(MCA_LATENCY - 2)) begin
                        state_r <= COMBINE;
                    end else begin
                        wait_r <= wait_r + CW'(1);
                    end
                end
                COMBINE: begin
                    est_out   <= sat_add(res_la, res_lb);
                    est_valid <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
